// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and decode helpers for the pipeline hazard/stall sequencer.
// Mnemonic codes mirror the core's define.svh numbering.
package pipeline_ctrl_pkg;

    localparam logic [5:0] MN_NOP   = 6'd0;
    localparam logic [5:0] MN_LUI   = 6'd1;
    localparam logic [5:0] MN_AUIPC = 6'd2;
    localparam logic [5:0] MN_JAL   = 6'd3;
    localparam logic [5:0] MN_JALR  = 6'd4;
    localparam logic [5:0] MN_BEQ   = 6'd5;
    localparam logic [5:0] MN_BNE   = 6'd6;
    localparam logic [5:0] MN_BLT   = 6'd7;
    localparam logic [5:0] MN_BGE   = 6'd8;
    localparam logic [5:0] MN_BLTU  = 6'd9;
    localparam logic [5:0] MN_BGEU  = 6'd10;
    localparam logic [5:0] MN_LB    = 6'd11;
    localparam logic [5:0] MN_LH    = 6'd12;
    localparam logic [5:0] MN_LW    = 6'd13;
    localparam logic [5:0] MN_LBU   = 6'd14;
    localparam logic [5:0] MN_LHU   = 6'd15;
    localparam logic [5:0] MN_SB    = 6'd16;
    localparam logic [5:0] MN_SH    = 6'd17;
    localparam logic [5:0] MN_SW    = 6'd18;
    localparam logic [5:0] MN_ADDI  = 6'd19;
    localparam logic [5:0] MN_SLTI  = 6'd20;
    localparam logic [5:0] MN_SLTIU = 6'd21;
    localparam logic [5:0] MN_XORI  = 6'd22;
    localparam logic [5:0] MN_ORI   = 6'd23;
    localparam logic [5:0] MN_ANDI  = 6'd24;
    localparam logic [5:0] MN_SLLI  = 6'd25;
    localparam logic [5:0] MN_SRLI  = 6'd26;
    localparam logic [5:0] MN_SRAI  = 6'd27;
    localparam logic [5:0] MN_ADD   = 6'd28;
    localparam logic [5:0] MN_SUB   = 6'd29;
    localparam logic [5:0] MN_SLL   = 6'd30;
    localparam logic [5:0] MN_SLT   = 6'd31;
    localparam logic [5:0] MN_SLTU  = 6'd32;
    localparam logic [5:0] MN_XOR   = 6'd33;
    localparam logic [5:0] MN_SRL   = 6'd34;
    localparam logic [5:0] MN_SRA   = 6'd35;
    localparam logic [5:0] MN_OR    = 6'd36;
    localparam logic [5:0] MN_AND   = 6'd37;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    // rs2 users: R-type, stores, branches
    function automatic logic uses_rs2(input logic [5:0] mnemonic);
        logic r;
        r = 1'b0;
        case (mnemonic)
            MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
            MN_SB, MN_SH, MN_SW,
            MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU,
            MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // rs1 users: every rs2 user plus I-type ALU, loads and JALR
    function automatic logic uses_rs1(input logic [5:0] mnemonic);
        logic r;
        r = uses_rs2(mnemonic);
        case (mnemonic)
            MN_JALR,
            MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
            MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI,
            MN_SLLI, MN_SRLI, MN_SRAI: r = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: stage enables/flushes,
// PC redirect, stale-fetch squash after a redirect, and stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       i_id_mnemonic,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_rd_wr,
    input  logic             i_ex_DM_OE,
    input  logic             i_ex_redirect,
    input  logic             i_im_ready,
    input  logic             i_mem_req,
    input  logic             i_dm_ready,
    output logic             o_pc_en,
    output logic             o_pc_redirect,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_mem_wb_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_e state_q;
    state_e state_d;

    logic use_rs1;
    logic use_rs2;
    logic load_use;
    logic dm_stall;
    logic redirect_ok;

    assign use_rs1  = uses_rs1(i_id_mnemonic);
    assign use_rs2  = uses_rs2(i_id_mnemonic);
    assign load_use = i_ex_DM_OE & i_ex_rd_wr & (i_ex_rd_addr != 5'd0) &
                      ((use_rs1 & (i_id_rs1_addr == i_ex_rd_addr)) |
                       (use_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));
    assign dm_stall    = i_mem_req & ~i_dm_ready;
    // EX keeps presenting the redirect while frozen, so it is simply retried later
    assign redirect_ok = i_ex_redirect & ~dm_stall;

    always_comb begin
        o_pc_en        = 1'b1;
        o_pc_redirect  = 1'b0;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b0;

        if (rst) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_en     = 1'b0;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
        end else begin
            if (dm_stall) begin
                o_pc_en        = 1'b0;
                o_if_id_en     = 1'b0;
                o_id_ex_en     = 1'b0;
                o_ex_mem_en    = 1'b0;
                o_mem_wb_flush = 1'b1;
            end else if (redirect_ok) begin
                o_pc_redirect = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (load_use) begin
                // one bubble suffices: next cycle the load sits in MEM and forwards
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
            end else if (!i_im_ready) begin
                o_pc_en       = 1'b0;
                o_if_id_flush = 1'b1;
            end

            // A wrong-path fetch is outstanding: whatever IF returns is discarded
            if (state_q == SQUASH) begin
                o_if_id_flush = 1'b1;
                if (!redirect_ok) begin
                    o_pc_en = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_ok) begin
            state_d = i_im_ready ? RUN : SQUASH;
        end else if ((state_q == SQUASH) && i_im_ready) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~o_pc_en & ~rst),
        .count (o_stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_ok & ~rst),
        .count (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle decode table plus multi-cycle
// redirect/squash/dm-stall/reset sequences; a 2-bit-counter copy checks saturation.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //  ex_mem_en, mem_wb_en, mem_wb_flush}
    localparam logic [8:0] DEF = 9'b101010110;
    localparam logic [8:0] LU  = 9'b000011110;
    localparam logic [8:0] IMW = 9'b001110110;
    localparam logic [8:0] RDR = 9'b111111110;
    localparam logic [8:0] DMS = 9'b000000011;
    localparam logic [8:0] SQD = 9'b000100011;
    localparam logic [8:0] RST = 9'b000101001;

    typedef struct {
        string      name;
        logic [5:0] mn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rd_wr;
        logic       dm_oe;
        logic       redir;
        logic       im_rdy;
        logic       mem_req;
        logic       dm_rdy;
        logic [8:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  id_mn;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wr, dm_oe, redir, im_rdy, mem_req, dm_rdy;
    logic        pc_en, pc_redir, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en,
                 mem_wb_fl;
    logic [31:0] stall_cnt, flush_cnt;
    logic        n_pc_en, n_pc_redir, n_if_id_en, n_if_id_fl, n_id_ex_en, n_id_ex_fl,
                 n_ex_mem_en, n_mem_wb_en, n_mem_wb_fl;
    logic [1:0]  n_stall_cnt, n_flush_cnt;
    logic [8:0]  ctl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, pc_redir, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en,
                  mem_wb_fl};

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_id_mnemonic(id_mn), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_ex_rd_addr(rd), .i_ex_rd_wr(rd_wr), .i_ex_DM_OE(dm_oe), .i_ex_redirect(redir),
        .i_im_ready(im_rdy), .i_mem_req(mem_req), .i_dm_ready(dm_rdy),
        .o_pc_en(pc_en), .o_pc_redirect(pc_redir), .o_if_id_en(if_id_en),
        .o_if_id_flush(if_id_fl), .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_fl),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en), .o_mem_wb_flush(mem_wb_fl),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .i_id_mnemonic(id_mn), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_ex_rd_addr(rd), .i_ex_rd_wr(rd_wr), .i_ex_DM_OE(dm_oe), .i_ex_redirect(redir),
        .i_im_ready(im_rdy), .i_mem_req(mem_req), .i_dm_ready(dm_rdy),
        .o_pc_en(n_pc_en), .o_pc_redirect(n_pc_redir), .o_if_id_en(n_if_id_en),
        .o_if_id_flush(n_if_id_fl), .o_id_ex_en(n_id_ex_en), .o_id_ex_flush(n_id_ex_fl),
        .o_ex_mem_en(n_ex_mem_en), .o_mem_wb_en(n_mem_wb_en), .o_mem_wb_flush(n_mem_wb_fl),
        .o_stall_cnt(n_stall_cnt), .o_flush_cnt(n_flush_cnt)
    );

    function automatic vec_t mk(input string name, input logic [5:0] mn, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] d, input logic wr,
                                input logic ld, input logic rdr, input logic imr,
                                input logic mrq, input logic dmr, input logic [8:0] e);
        vec_t v;
        v.name = name; v.mn = mn; v.rs1 = r1; v.rs2 = r2; v.rd = d; v.rd_wr = wr;
        v.dm_oe = ld; v.redir = rdr; v.im_rdy = imr; v.mem_req = mrq; v.dm_rdy = dmr;
        v.exp = e;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_mn = v.mn; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; rd_wr = v.rd_wr; dm_oe = v.dm_oe;
        redir = v.redir; im_rdy = v.im_rdy; mem_req = v.mem_req; dm_rdy = v.dm_rdy;
    endtask

    // Idle ADD x1,x2,x3 with a non-load in EX; only the knobs under test change
    task automatic idle(input logic rdr, input logic imr, input logic mrq, input logic dmr);
        apply(mk("idle", MN_ADD, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, rdr, imr, mrq, dmr, DEF));
    endtask

    // Compares outputs and counters (counters reflect completed cycles), then
    // advances the counter model by this cycle's expected pc_en / pc_redirect.
    task automatic check(input string name, input logic [8:0] exp);
        int ns, nf;
        ns = (exp_stall > 3) ? 3 : exp_stall;
        nf = (exp_flush > 3) ? 3 : exp_flush;
        checks++;
        if (ctl !== exp) begin
            errors++;
            $display("FAIL %s ctl got %b want %b", name, ctl, exp);
        end
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (flush_cnt !== 32'(exp_flush)) begin
            errors++;
            $display("FAIL %s flush_cnt got %0d want %0d", name, flush_cnt, exp_flush);
        end
        checks++;
        if ({n_stall_cnt, n_flush_cnt} !== {2'(ns), 2'(nf)}) begin
            errors++;
            $display("FAIL %s sat_cnt got %0d/%0d want %0d/%0d", name, n_stall_cnt,
                     n_flush_cnt, ns, nf);
        end
        if (!rst) begin
            if (!exp[8]) exp_stall++;
            if (exp[7]) exp_flush++;
        end
    endtask

    task automatic cyc(input string name, input logic [8:0] exp);
        #1;
        check(name, exp);
        @(negedge clk);
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk("plain_add",     MN_ADD,  5'd2, 5'd3, 5'd1, 1, 0, 0, 1, 0, 1, DEF);
        vecs[1]  = mk("lu_rs2",        MN_ADD,  5'd1, 5'd5, 5'd5, 1, 1, 0, 1, 0, 1, LU);
        vecs[2]  = mk("lu_rs1_addi",   MN_ADDI, 5'd5, 5'd0, 5'd5, 1, 1, 0, 1, 0, 1, LU);
        vecs[3]  = mk("addi_rs2_unused", MN_ADDI, 5'd1, 5'd5, 5'd5, 1, 1, 0, 1, 0, 1, DEF);
        vecs[4]  = mk("lw_x0",         MN_ADD,  5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 0, 1, DEF);
        vecs[5]  = mk("lui_no_src",    MN_LUI,  5'd5, 5'd5, 5'd5, 1, 1, 0, 1, 0, 1, DEF);
        vecs[6]  = mk("alu_fwd",       MN_ADD,  5'd5, 5'd5, 5'd5, 1, 0, 0, 1, 0, 1, DEF);
        vecs[7]  = mk("lu_sw_rs2",     MN_SW,   5'd1, 5'd5, 5'd5, 1, 1, 0, 1, 0, 1, LU);
        vecs[8]  = mk("lu_beq_rs1",    MN_BEQ,  5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 0, 1, LU);
        vecs[9]  = mk("lu_jalr",       MN_JALR, 5'd5, 5'd0, 5'd5, 1, 1, 0, 1, 0, 1, LU);
        vecs[10] = mk("jal_no_src",    MN_JAL,  5'd5, 5'd5, 5'd5, 1, 1, 0, 1, 0, 1, DEF);
        vecs[11] = mk("load_no_wr",    MN_ADD,  5'd5, 5'd5, 5'd5, 0, 1, 0, 1, 0, 1, DEF);
        vecs[12] = mk("im_wait",       MN_ADD,  5'd2, 5'd3, 5'd1, 1, 0, 0, 0, 0, 1, IMW);
        vecs[13] = mk("lu_over_im",    MN_ADD,  5'd5, 5'd3, 5'd5, 1, 1, 0, 0, 0, 1, LU);
        vecs[14] = mk("redir_over_lu", MN_ADD,  5'd5, 5'd3, 5'd5, 1, 1, 1, 1, 0, 1, RDR);
        vecs[15] = mk("dm_stall",      MN_ADD,  5'd2, 5'd3, 5'd1, 1, 0, 0, 1, 1, 0, DMS);
        vecs[16] = mk("dm_over_lu",    MN_ADD,  5'd5, 5'd3, 5'd5, 1, 1, 1, 0, 1, 0, DMS);
        vecs[17] = mk("dm_ready",      MN_ADD,  5'd2, 5'd3, 5'd1, 1, 0, 0, 1, 1, 1, DEF);

        idle(1'b0, 1'b1, 1'b0, 1'b1);
        #3;
        check("reset_hold", RST);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            cyc(vecs[i].name, vecs[i].exp);
        end

        // Load-use bubble lasts exactly one cycle
        apply(mk("lu", MN_ADD, 5'd5, 5'd1, 5'd5, 1, 1, 0, 1, 0, 1, LU));
        cyc("lu_seq_bubble", LU);
        apply(mk("lu", MN_ADD, 5'd5, 5'd1, 5'd6, 1, 0, 0, 1, 0, 1, DEF));
        cyc("lu_seq_release", DEF);

        // Redirect with fetch ready stays in RUN
        idle(1'b1, 1'b1, 1'b0, 1'b1); cyc("redir_rdy", RDR);
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("redir_rdy_run", DEF);

        // Redirect during fetch wait -> SQUASH until the stale word returns
        idle(1'b1, 1'b0, 1'b0, 1'b1); cyc("sq_enter", RDR);
        idle(1'b0, 1'b0, 1'b0, 1'b1); cyc("sq_wait1", IMW);
        cyc("sq_wait2", IMW);
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("sq_stale_word", IMW);
        cyc("sq_back_run", DEF);

        // New redirect inside SQUASH
        idle(1'b1, 1'b0, 1'b0, 1'b1); cyc("sq2_enter", RDR);
        cyc("sq2_redir_wait", RDR);
        idle(1'b1, 1'b1, 1'b0, 1'b1); cyc("sq2_redir_rdy", RDR);
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("sq2_run", DEF);

        // SQUASH exits even while data memory stalls
        idle(1'b1, 1'b0, 1'b0, 1'b1); cyc("sq3_enter", RDR);
        idle(1'b0, 1'b1, 1'b1, 1'b0); cyc("sq3_dm_stall", SQD);
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("sq3_run", DEF);

        // dm_stall holds off the redirect until data memory completes
        idle(1'b1, 1'b1, 1'b1, 1'b0);
        cyc("dm_redir1", DMS);
        cyc("dm_redir2", DMS);
        cyc("dm_redir3", DMS);
        idle(1'b1, 1'b1, 1'b1, 1'b1); cyc("dm_redir_accept", RDR);
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("dm_redir_after", DEF);

        // Asynchronous reset in the middle of SQUASH
        idle(1'b1, 1'b0, 1'b0, 1'b1); cyc("rst_sq_enter", RDR);
        idle(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_sq_pre", IMW);
        #1;
        rst = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("rst_async", RST);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0, 1'b1, 1'b0, 1'b1); cyc("rst_release_run", DEF);
        cyc("rst_release_run2", DEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes decoded ID-stage fields (rs1/rs2 address, 6-bit mnemonic), EX-stage load/redirect status, and the instruction- and data-memory ready handshakes.
- Drives per-stage pipeline-register enables and flushes, plus PC update and redirect select.
- Squashes a stale in-flight fetch after a redirect and keeps saturating stall/flush performance counters.
- EX/MEM and MEM/WB forwarding exist elsewhere, so only load-use needs a bubble.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_id_mnemonic  in  6  mnemonic of instruction in ID (codes from define.svh)
i_id_rs1_addr  in  5  ID rs1 address
i_id_rs2_addr  in  5  ID rs2 address
i_ex_rd_addr  in  5  EX destination register
i_ex_rd_wr  in  1  EX instruction writes rd
i_ex_DM_OE  in  1  EX instruction is a load
i_ex_redirect  in  1  EX resolved taken branch / JAL / JALR; held while EX is frozen
i_im_ready  in  1  instruction memory returns fetch word this cycle
i_mem_req  in  1  MEM-stage instruction is a load/store
i_dm_ready  in  1  data memory completes access this cycle
o_pc_en  out  1  PC register update
o_pc_redirect  out  1  PC loads EX target instead of PC+4
o_if_id_en / o_if_id_flush  out  1 each  IF/ID enable / insert bubble
o_id_ex_en / o_id_ex_flush  out  1 each
o_ex_mem_en  out  1
o_mem_wb_en / o_mem_wb_flush  out  1 each
o_stall_cnt  out  CNT_W  cycles with o_pc_en=0
o_flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- Source-register usage, derived from i_id_mnemonic:
  - No sources: LUI, AUIPC, JAL, NOP.
  - rs1 only: I-type ALU, loads, JALR.
  - rs1 and rs2: R-type, stores, branches.
- Conditions:
  - load_use = i_ex_DM_OE & i_ex_rd_wr & (i_ex_rd_addr≠0) & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)).
  - dm_stall = i_mem_req & ~i_dm_ready.
- Priority: dm_stall > redirect > load_use > fetch stall.
- All stage control outputs are combinational from state and current inputs. Default: every enable=1, every flush=0, o_pc_redirect=0.
- dm_stall:
  - pc/if_id/id_ex/ex_mem enables=0, mem_wb_flush=1.
  - Redirect is not accepted; EX holds it.
- Redirect accepted:
  - o_pc_en=1, o_pc_redirect=1, if_id_flush=1, id_ex_flush=1.
  - o_flush_cnt+1.
- load_use: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. Exactly one bubble, since next cycle the load is in MEM.
- ~i_im_ready (no higher condition): o_pc_en=0, o_if_id_flush=1.
- States: RUN, SQUASH.
  - RUN→SQUASH: redirect accepted while i_im_ready=0, because the wrong-path fetch is still outstanding.
  - In SQUASH, on top of the rules above, IF always bubbles: if_id_flush=1, and o_pc_en=0 unless a new redirect is accepted.
  - SQUASH→RUN: on i_im_ready=1, which discards the stale word. This transition happens even during dm_stall.
  - A new redirect accepted in SQUASH loads the new target. If i_im_ready=1 in that same cycle, go to RUN; the returned word is stale and flushed.
- Counters:
  - o_stall_cnt +1 on each cycle with o_pc_en=0; o_flush_cnt +1 on each accepted redirect.
  - Both saturate at all-ones.
- Reset (async, any time including mid-SQUASH):
  - state=RUN, counters=0.
  - While rst is high: all enables=0, all flushes=1, o_pc_redirect=0.
  - First cycle after deassert: RUN defaults.

Decomposition:
- Mnemonic codes stay in include/define.svh.
- New package pipeline_ctrl_pkg holds:
  - the state enum (RUN, SQUASH);
  - functions uses_rs1(mnemonic) and uses_rs2(mnemonic).
- One sub-module is natural: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Load-use: EX=LW x5 (rd_wr=1, DM_OE=1, rd=5), ID=ADD x6,x5,x1, im/dm ready → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1; o_stall_cnt=1.
- No false hazard: EX=LW x0, ID=ADD x6,x0,x0; then EX=LW x5, ID=LUI x5 → no stall in either case.
- Redirect with im ready: i_ex_redirect=1 → pc_redirect=1, if_id_flush=1, id_ex_flush=1; o_flush_cnt=1; state stays RUN.
- Redirect during fetch wait:
  - redirect with i_im_ready=0 → SQUASH.
  - Hold i_im_ready=0 for 2 cycles → if_id_flush=1 and pc_en=0 each cycle.
  - i_im_ready=1 → word flushed, RUN next cycle.
- dm_stall over redirect: i_mem_req=1, i_dm_ready=0 for 3 cycles with i_ex_redirect=1 → pc_redirect=0 and mem_wb_flush=1 each cycle; redirect accepted on the cycle i_dm_ready=1; o_stall_cnt=3.
- Reset mid-SQUASH: assert rst asynchronously → state RUN, counters 0, all flushes=1 immediately; deassert → defaults.
